// File: rtl/vid_blit_pkg.sv
// vid_blit_pkg: CPU port addresses and FSM state encoding shared by the
// blitter and anything that talks to it.
package vid_blit_pkg;

   // CPU data-space register map
   localparam logic [15:0] A_ADDR  = 16'h0020;  // pointer shift-in
   localparam logic [15:0] A_BANKR = 16'h0021;  // display bank select
   localparam logic [15:0] A_BANKW = 16'h0022;  // write bank select
   localparam logic [15:0] A_DATA  = 16'h0023;  // single write at ptr
   localparam logic [15:0] A_CNTL  = 16'h0024;  // fill count low byte
   localparam logic [15:0] A_CNTH  = 16'h0025;  // fill count high byte
   localparam logic [15:0] A_FILL  = 16'h0026;  // start fill with value
   localparam logic [15:0] A_CTRL  = 16'h0027;  // status read / abort write
   localparam logic [15:0] A_STRL  = 16'h0028;  // fill stride low byte
   localparam logic [15:0] A_STRH  = 16'h0029;  // fill stride high byte

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

endpackage

// File: rtl/vid_blit.sv
// vid_blit: CPU-programmed video-memory blitter. Single writes through a
// post-incrementing pointer, plus a hardware fill of N bytes into a latched
// bank. Optional build macro VID_BLIT_STRIDE_EN adds a programmable fill
// stride register at 0x28/0x29; without it the fill always steps by one.
module vid_blit
   import vid_blit_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_address,
   input  logic [7:0]  i_data,
   input  logic        i_we,
   output logic [7:0]  o_data,
   output logic [16:0] o_vid_address,
   output logic [7:0]  o_vid_data,
   output logic        o_vid_we,
   output logic        o_vid_bank_r
);

   state_t      r_state;
   state_t      w_state_next;

   logic [15:0] r_ptr,        w_ptr_next;
   logic [15:0] r_count,      w_count_next;
   logic [15:0] r_remain,     w_remain_next;
   logic [7:0]  r_fill_val,   w_fill_val_next;
   logic        r_fill_bank,  w_fill_bank_next;
   logic        r_bank_w,     w_bank_w_next;
   logic        r_bank_r,     w_bank_r_next;
   logic        r_overrun,    w_overrun_next;
   logic        r_vid_we,     w_vid_we_next;
   logic [16:0] r_vid_address, w_vid_address_next;
   logic [7:0]  r_vid_data,   w_vid_data_next;

   logic [15:0] w_step;
   logic        w_busy;
   logic        w_drop_addr;

`ifdef VID_BLIT_STRIDE_EN
   logic [15:0] r_stride, w_stride_next;
   assign w_step = r_stride;
`else
   assign w_step = 16'd1;
`endif

   assign w_busy = (r_state == ST_FILL);

   // Registers that a running fill owns; writing them mid-fill is an overrun.
   assign w_drop_addr = (i_address == A_ADDR)  || (i_address == A_BANKW) ||
                        (i_address == A_DATA)  || (i_address == A_CNTL)  ||
                        (i_address == A_CNTH)  || (i_address == A_FILL);

   // Next-state and datapath decode: CPU writes in IDLE, fill stepping in FILL
   always_comb begin
      w_state_next       = r_state;
      w_ptr_next         = r_ptr;
      w_count_next       = r_count;
      w_remain_next      = r_remain;
      w_fill_val_next    = r_fill_val;
      w_fill_bank_next   = r_fill_bank;
      w_bank_w_next      = r_bank_w;
      w_bank_r_next      = r_bank_r;
      w_overrun_next     = r_overrun;
      w_vid_we_next      = 1'b0;
      w_vid_address_next = r_vid_address;
      w_vid_data_next    = r_vid_data;
`ifdef VID_BLIT_STRIDE_EN
      w_stride_next      = r_stride;
`endif

      case (r_state)
         ST_IDLE: begin
            if (i_we) begin
               case (i_address)
                  A_ADDR:  w_ptr_next = {r_ptr[7:0], i_data};
                  A_BANKW: w_bank_w_next = i_data[0];
                  A_DATA: begin
                     w_vid_we_next      = 1'b1;
                     w_vid_address_next = {r_bank_w, r_ptr};
                     w_vid_data_next    = i_data;
                     w_ptr_next         = r_ptr + 16'd1;
                  end
                  A_CNTL:  w_count_next = {r_count[15:8], i_data};
                  A_CNTH:  w_count_next = {i_data, r_count[7:0]};
                  A_FILL: begin
                     w_fill_val_next  = i_data;
                     w_fill_bank_next = r_bank_w;
                     // The first fill write is issued straight from the
                     // command so vid_we rises the very next cycle.
                     if (r_count != 16'd0) begin
                        w_state_next       = ST_FILL;
                        w_vid_we_next      = 1'b1;
                        w_vid_address_next = {r_bank_w, r_ptr};
                        w_vid_data_next    = i_data;
                        w_ptr_next         = r_ptr + w_step;
                        w_remain_next      = r_count - 16'd1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_FILL: begin
            if (r_remain != 16'd0) begin
               w_vid_we_next      = 1'b1;
               w_vid_address_next = {r_fill_bank, r_ptr};
               w_vid_data_next    = r_fill_val;
               w_ptr_next         = r_ptr + w_step;
               w_remain_next      = r_remain - 16'd1;
            end else begin
               w_state_next = ST_IDLE;
            end
            if (i_we && w_drop_addr) begin
               w_overrun_next = 1'b1;
            end
         end
      endcase

      // Display bank, stride and abort are honoured in every state
      if (i_we) begin
         if (i_address == A_BANKR) begin
            w_bank_r_next = i_data[0];
         end
`ifdef VID_BLIT_STRIDE_EN
         if (i_address == A_STRL) begin
            w_stride_next = {r_stride[15:8], i_data};
         end
         if (i_address == A_STRH) begin
            w_stride_next = {i_data, r_stride[7:0]};
         end
`endif
         if (i_address == A_CTRL) begin
            w_state_next   = ST_IDLE;
            w_overrun_next = 1'b0;
            w_vid_we_next  = 1'b0;
            w_remain_next  = 16'd0;
         end
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Datapath and video-port registers; async reset kills vid_we at once
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr         <= 16'd0;
         r_count       <= 16'd0;
         r_remain      <= 16'd0;
         r_fill_val    <= 8'd0;
         r_fill_bank   <= 1'b0;
         r_bank_w      <= 1'b0;
         r_bank_r      <= 1'b0;
         r_overrun     <= 1'b0;
         r_vid_we      <= 1'b0;
         r_vid_address <= 17'd0;
         r_vid_data    <= 8'd0;
      end else begin
         r_ptr         <= w_ptr_next;
         r_count       <= w_count_next;
         r_remain      <= w_remain_next;
         r_fill_val    <= w_fill_val_next;
         r_fill_bank   <= w_fill_bank_next;
         r_bank_w      <= w_bank_w_next;
         r_bank_r      <= w_bank_r_next;
         r_overrun     <= w_overrun_next;
         r_vid_we      <= w_vid_we_next;
         r_vid_address <= w_vid_address_next;
         r_vid_data    <= w_vid_data_next;
      end
   end

`ifdef VID_BLIT_STRIDE_EN
   // Fill stride register, defaults to a step of one
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stride <= 16'd1;
      end else begin
         r_stride <= w_stride_next;
      end
   end
`endif

   // Combinational register readback
   always_comb begin
      o_data = 8'h00;
      case (i_address)
         A_CTRL:  o_data = {6'b0, r_overrun, w_busy};
         A_ADDR:  o_data = r_ptr[7:0];
`ifdef VID_BLIT_STRIDE_EN
         A_STRL:  o_data = r_stride[7:0];
         A_STRH:  o_data = r_stride[15:8];
`endif
         default: o_data = 8'h00;
      endcase
   end

   assign o_vid_we      = r_vid_we;
   assign o_vid_address = r_vid_address;
   assign o_vid_data    = r_vid_data;
   assign o_vid_bank_r  = r_bank_r;

endmodule

// File: tb/tb_vid_blit.sv
// tb_vid_blit: directed test of vid_blit with a scoreboard of expected
// video writes; a monitor pops and compares on every vid_we cycle.
`timescale 1ns/1ps
module tb_vid_blit;
   import vid_blit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] address = 16'h0000;
   logic [7:0]  data_i = 8'h00;
   logic        we = 1'b0;
   logic [7:0]  data_o;
   logic [16:0] vid_address;
   logic [7:0]  vid_data;
   logic        vid_we;
   logic        vid_bank_r;

   int n_checks = 0;
   int n_errors = 0;
   int n_writes = 0;
   logic [24:0] exp_q[$];

`ifdef VID_BLIT_STRIDE_EN
   localparam int STEP320 = 320;
   localparam logic [7:0] STR_RST_LO = 8'h01;
`else
   localparam int STEP320 = 1;
   localparam logic [7:0] STR_RST_LO = 8'h00;
`endif

   vid_blit dut (
      .i_clk(clk), .i_rst(rst), .i_address(address), .i_data(data_i), .i_we(we),
      .o_data(data_o), .o_vid_address(vid_address), .o_vid_data(vid_data),
      .o_vid_we(vid_we), .o_vid_bank_r(vid_bank_r)
   );

   always #20 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: present one CPU write for the following posedge
   task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
      address = a; data_i = d; we = 1'b1;
      @(negedge clk);
      we = 1'b0; address = 16'h0000;
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] v);
      address = a;
      #1;
      v = data_o;
   endtask

   task automatic wait_idle(input int max, output int cycles);
      logic [7:0] s;
      cycles = 0;
      rd(A_CTRL, s);
      while (s[0] && cycles < max) begin
         @(negedge clk);
         cycles++;
         rd(A_CTRL, s);
      end
   endtask

   // Scoreboard monitor: every vid_we cycle must match the next expected write
   always @(negedge clk) begin
      if (vid_we === 1'b1) begin
         logic [24:0] e;
         n_writes++;
         n_checks++;
         assert (exp_q.size() != 0) else begin
            n_errors++;
            $error("FAIL vid_unexpected observed=%0h/%0h expected=none", vid_address, vid_data);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            assert ({vid_address, vid_data} === e) else begin
               n_errors++;
               $error("FAIL vid_write observed=%0h/%0h expected=%0h/%0h",
                      vid_address, vid_data, e[24:8], e[7:0]);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      int cyc, k, base;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_vid_we", vid_we, 0);
      chk("rst_vid_address", vid_address, 0);
      chk("rst_vid_data", vid_data, 0);
      chk("rst_bank_r", vid_bank_r, 0);
      rd(A_CTRL, v); chk("rst_status", v, 8'h00);
      rd(A_ADDR, v); chk("rst_ptr", v, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single DATA write through the pointer into bank 1
      cpu_wr(A_ADDR, 8'h12);
      cpu_wr(A_ADDR, 8'h34);
      cpu_wr(A_BANKW, 8'h01);
      exp_q.push_back({17'h11234, 8'hAA});
      cpu_wr(A_DATA, 8'hAA);
      @(negedge clk);
      rd(A_ADDR, v); chk("data_ptr_inc", v, 8'h35);
      chk("data_sb_empty", exp_q.size(), 0);

      // Display bank select
      cpu_wr(A_BANKR, 8'h01); chk("bank_r_set", vid_bank_r, 1);
      cpu_wr(A_BANKR, 8'hFE); chk("bank_r_clr", vid_bank_r, 0);

      // Fill of 4 across the 0xFFFF wrap, bank 0
      cpu_wr(A_BANKW, 8'h00);
      cpu_wr(A_ADDR, 8'hFF);
      cpu_wr(A_ADDR, 8'hFE);
      cpu_wr(A_CNTL, 8'h04);
      cpu_wr(A_CNTH, 8'h00);
      exp_q.push_back({17'h0FFFE, 8'h55});
      exp_q.push_back({17'h0FFFF, 8'h55});
      exp_q.push_back({17'h00000, 8'h55});
      exp_q.push_back({17'h00001, 8'h55});
      cpu_wr(A_FILL, 8'h55);
      wait_idle(20, cyc);
      chk("wrap_busy_cycles", cyc, 4);
      rd(A_CTRL, v); chk("wrap_status_done", v, 8'h00);
      rd(A_ADDR, v); chk("wrap_ptr", v, 8'h02);
      chk("wrap_sb_empty", exp_q.size(), 0);

      // Zero-count fill is a no-op
      cpu_wr(A_CNTL, 8'h00);
      base = n_writes;
      cpu_wr(A_FILL, 8'h77);
      repeat (3) @(negedge clk);
      rd(A_CTRL, v); chk("cnt0_status", v, 8'h00);
      chk("cnt0_no_writes", n_writes - base, 0);

      // Overrun: DATA during a 100-byte fill is dropped
      cpu_wr(A_ADDR, 8'h00);
      cpu_wr(A_ADDR, 8'h00);
      cpu_wr(A_CNTL, 8'h64);
      for (int i = 0; i < 100; i++) exp_q.push_back({1'b0, 16'(i), 8'h5A});
      cpu_wr(A_FILL, 8'h5A);
      cpu_wr(A_DATA, 8'h99);
      rd(A_CTRL, v); chk("ovr_status_busy", v, 8'h03);
      wait_idle(200, cyc);
      chk("ovr_timeout", cyc < 200, 1);
      rd(A_CTRL, v); chk("ovr_status_done", v, 8'h02);
      rd(A_ADDR, v); chk("ovr_ptr", v, 8'h64);
      chk("ovr_sb_empty", exp_q.size(), 0);
      cpu_wr(A_CTRL, 8'h00);
      rd(A_CTRL, v); chk("ovr_cleared", v, 8'h00);

      // Abort at the 10th write of a 100-byte fill
      cpu_wr(A_ADDR, 8'h10);
      cpu_wr(A_ADDR, 8'h00);
      for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, 16'h1000 + 16'(i), 8'h3C});
      base = n_writes;
      cpu_wr(A_FILL, 8'h3C);
      k = (vid_we === 1'b1) ? 1 : 0;
      cyc = 0;
      while (k < 10 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (vid_we === 1'b1) k++;
      end
      chk("abort_reached_10", k, 10);
      cpu_wr(A_CTRL, 8'h00);
      chk("abort_vid_we", vid_we, 0);
      rd(A_CTRL, v); chk("abort_status", v, 8'h00);
      repeat (3) @(negedge clk);
      chk("abort_write_count", n_writes - base, 10);
      chk("abort_sb_empty", exp_q.size(), 0);

      // Stride fill (step 320 when the stride register exists, else 1)
      cpu_wr(A_ADDR, 8'h00);
      cpu_wr(A_ADDR, 8'h00);
      cpu_wr(A_STRL, 8'h40);
      cpu_wr(A_STRH, 8'h01);
      rd(A_STRL, v); chk("stride_read_lo", v, (STEP320 == 320) ? 8'h40 : 8'h00);
      cpu_wr(A_CNTL, 8'h03);
      for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 16'(i * STEP320), 8'h11});
      cpu_wr(A_FILL, 8'h11);
      wait_idle(20, cyc);
      chk("stride_busy_cycles", cyc, 3);
      chk("stride_sb_empty", exp_q.size(), 0);

      // Reset during a fill stops writes immediately
      cpu_wr(A_ADDR, 8'h00);
      cpu_wr(A_ADDR, 8'h00);
      cpu_wr(A_CNTL, 8'h64);
      for (int i = 0; i < 100; i++) exp_q.push_back({1'b0, 16'(i * STEP320), 8'hC3});
      cpu_wr(A_FILL, 8'hC3);
      repeat (5) @(negedge clk);
      chk("prerst_vid_we", vid_we, 1);
      rst = 1'b1;
      #1;
      chk("midrst_vid_we", vid_we, 0);
      chk("midrst_vid_address", vid_address, 0);
      rd(A_CTRL, v); chk("midrst_status", v, 8'h00);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rd(A_STRL, v); chk("postrst_stride_lo", v, STR_RST_LO);
      rd(A_ADDR, v); chk("postrst_ptr", v, 8'h00);
      base = n_writes;
      repeat (3) @(negedge clk);
      chk("postrst_no_writes", n_writes - base, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
